lm80c_ps2_matrix: RTL and testbench
===================================

// Module: lm80c_ps2_matrix
// PURPOSE
//  PS/2 keyboard receiver and decoder. Drives the 8x8 KM key matrix that the
//  PSG port-scan logic reads. Receives PS/2 frames, tracks E0/F0/E1 prefixes,
//  maps make/break codes to row/col and holds one bit per key (0 = pressed).
// PARAMETERS
//  PS2_FILTER   8       consecutive equal sys_clock samples required to accept a ps2_clk level change
//  TIMEOUT_CYC  50000   sys_clock cycles with no ps2_clk fall mid-frame before the frame is aborted
// PORTS
//  sys_clock   in   1       system clock; the only clock
//  RESET_n     in   1       asynchronous active-low reset
//  ps2_clk     in   1       PS/2 clock, asynchronous to sys_clock
//  ps2_data    in   1       PS/2 data, asynchronous to sys_clock
//  KM[7:0]     out  8x8     matrix row r, bit c; 0 = key pressed
//  scancode    out  8       last received byte
//  key_valid   out  1       1-cycle pulse when a KM bit is written
//  frame_err   out  1       1-cycle pulse on a bad start, stop or parity bit, or on a timeout
// BEHAVIOUR
//  Reset: KM all 8'hFF; scancode 8'h00; key_valid 0; frame_err 0; FSMs in IDLE; ext, brk and skip cleared.
//  Input: ps2_clk and ps2_data each pass a 2-flop synchroniser.
//   Filtered clk changes only after PS2_FILTER equal samples.
//   A falling edge of the filtered clk samples the synchronised data.
//  Frame FSM, one bit per falling edge:
//   IDLE: data=0 -> DATA, bit counter 0; data=1 -> stay in IDLE, no error.
//   DATA: shift LSB-first; after 8 bits -> PARITY.
//   PARITY: store the parity bit -> STOP.
//   STOP: data=1 -> byte_rdy pulse next cycle, then IDLE.
//         data=0 -> frame_err pulse, byte discarded, IDLE.
//   Timeout counter: reset on every falling edge; counts only outside IDLE.
//    Reaching TIMEOUT_CYC -> frame_err pulse, return to IDLE, partial byte discarded.
//  Decode, one cycle after byte_rdy:
//   scancode <= byte for every accepted byte.
//   skip != 0 -> skip decrements, byte ignored.
//   E1 -> skip = 7 (Pause sequence dropped).
//   E0 -> ext = 1.
//   F0 -> brk = 1.
//   AA, FA, EE, FE -> ignored; ext and brk cleared.
//   Any other byte: lookup {ext, byte} -> {hit, row[2:0], col[2:0]}.
//    hit: KM[row][col] <= brk, key_valid pulse.
//    miss: no KM change, no pulse.
//    Either way ext and brk are cleared.
//  Total latency, STOP-bit falling edge to KM update: 2 sys_clock cycles.
//  Make of an already-held key or break of a released key: idempotent rewrite; key_valid still pulses.
//  Map entries are fixed (full table in the lookup function), including:
//   1C->r2c1 (A)   5A->r1c6 (Enter)   12->r0c7 (LShift)
//   29->r4c4 (Space)   E0 75->r7c3 (Up)   unmapped->miss
//  RESET_n asserted mid-frame: immediate return to reset state, all held keys released.
// CONFIGURATION
//  PS2_PARITY_CHECK_EN defined:
//   In STOP, also require odd parity over data plus the stored parity bit.
//   Mismatch -> frame_err pulse, byte discarded.
//  PS2_PARITY_CHECK_EN not defined: the parity bit is sampled and ignored.
// TESTING
//  1: send 1C (odd parity correct) -> KM[2] = 8'hFD, key_valid pulses once, scancode = 1C.
//  2: after test 1, send F0 1C -> KM[2] = 8'hFF; scancode = 1C; one key_valid pulse, on the 1C.
//  3: send E0 75, then 75 -> KM[7] = 8'hF7 after the first pair.
//     The plain 75 is a miss and leaves KM unchanged.
//  4: send 1C with stop bit 0 -> frame_err pulse, KM unchanged.
//     Stop ps2_clk after 4 bits -> frame_err after TIMEOUT_CYC cycles; the next good frame decodes.
//  5: with PS2_PARITY_CHECK_EN, send 5A with wrong parity -> frame_err, KM[1] = FF.
//     Without the macro -> KM[1] = 8'hBF.
//  6: send E1 14 77 E1 F0 14 F0 77, then 29 -> KM unchanged during the Pause bytes.
//     KM[4] = 8'hEF after 29; assert RESET_n mid-frame -> KM all FF.

Source files
------------

// File: rtl/lm80c_ps2_matrix_if.sv
// -----------------------------------------------------------------------------
// lm80c_ps2_matrix_if
// Groups the PS/2 line inputs and the key-matrix outputs of lm80c_ps2_matrix.
//   ps2_clk, ps2_data : PS/2 lines from the keyboard (asynchronous)
//   KM                : 8x8 key matrix, KM[row][col], 0 = key pressed
//   scancode          : last byte accepted from the keyboard
//   key_valid         : 1-cycle pulse whenever a KM bit is written
//   frame_err         : 1-cycle pulse on a framing/parity error or a timeout
// Modports:
//   master : the decoder (samples the PS/2 lines, drives the matrix)
//   slave  : the environment (drives the PS/2 lines, reads the matrix)
// -----------------------------------------------------------------------------
interface lm80c_ps2_matrix_if;
   logic            ps2_clk;
   logic            ps2_data;
   logic [7:0][7:0] KM;
   logic [7:0]      scancode;
   logic            key_valid;
   logic            frame_err;

   modport master (
      input  ps2_clk, ps2_data,
      output KM, scancode, key_valid, frame_err
   );

   modport slave (
      output ps2_clk, ps2_data,
      input  KM, scancode, key_valid, frame_err
   );
endinterface

// File: rtl/lm80c_ps2_matrix.sv
// -----------------------------------------------------------------------------
// lm80c_ps2_matrix
// PS/2 keyboard receiver and scan-code decoder feeding the 8x8 key matrix that
// the PSG port-scan logic reads. Frames are received on falling edges of a
// synchronised and glitch-filtered ps2_clk; accepted bytes are decoded with
// E0 (extended), F0 (break) and E1 (Pause, next 7 bytes dropped) tracking.
// Ports:
//   sys_clock : system clock, the only clock
//   RESET_n   : asynchronous active-low reset (releases every key)
//   bus       : lm80c_ps2_matrix_if.master (PS/2 lines in, matrix out)
// Parameters:
//   PS2_FILTER  : equal samples needed before the filtered ps2_clk changes
//   TIMEOUT_CYC : idle cycles mid-frame before the frame is aborted
// Configuration macro:
//   PS2_PARITY_CHECK_EN : when defined, odd parity is enforced in the STOP
//                         state; otherwise the parity bit is sampled and ignored.
// -----------------------------------------------------------------------------
module lm80c_ps2_matrix #(
   parameter int PS2_FILTER  = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic                 sys_clock,
   input  logic                 RESET_n,
   lm80c_ps2_matrix_if.master   bus
);

   localparam int FW = $clog2(PS2_FILTER + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} frame_state_e;

   typedef struct packed {
      logic       hit;
      logic [2:0] row;
      logic [2:0] col;
   } key_map_t;

   // Fixed scan-code map: {ext, code} -> {hit, row, col}.
   function automatic key_map_t lookup(input logic [8:0] code);
      key_map_t m;
      m = '{hit: 1'b0, row: 3'd0, col: 3'd0};
      case (code)
         9'h016: m = '{1'b1, 3'd0, 3'd0}; // 1
         9'h01E: m = '{1'b1, 3'd0, 3'd1}; // 2
         9'h026: m = '{1'b1, 3'd0, 3'd2}; // 3
         9'h025: m = '{1'b1, 3'd0, 3'd3}; // 4
         9'h02E: m = '{1'b1, 3'd0, 3'd4}; // 5
         9'h036: m = '{1'b1, 3'd0, 3'd5}; // 6
         9'h03D: m = '{1'b1, 3'd0, 3'd6}; // 7
         9'h012: m = '{1'b1, 3'd0, 3'd7}; // LShift
         9'h015: m = '{1'b1, 3'd1, 3'd0}; // Q
         9'h01D: m = '{1'b1, 3'd1, 3'd1}; // W
         9'h024: m = '{1'b1, 3'd1, 3'd2}; // E
         9'h02D: m = '{1'b1, 3'd1, 3'd3}; // R
         9'h02C: m = '{1'b1, 3'd1, 3'd4}; // T
         9'h035: m = '{1'b1, 3'd1, 3'd5}; // Y
         9'h05A: m = '{1'b1, 3'd1, 3'd6}; // Enter
         9'h059: m = '{1'b1, 3'd1, 3'd7}; // RShift
         9'h014: m = '{1'b1, 3'd2, 3'd0}; // LCtrl
         9'h01C: m = '{1'b1, 3'd2, 3'd1}; // A
         9'h01B: m = '{1'b1, 3'd2, 3'd2}; // S
         9'h023: m = '{1'b1, 3'd2, 3'd3}; // D
         9'h02B: m = '{1'b1, 3'd2, 3'd4}; // F
         9'h034: m = '{1'b1, 3'd2, 3'd5}; // G
         9'h033: m = '{1'b1, 3'd2, 3'd6}; // H
         9'h03B: m = '{1'b1, 3'd2, 3'd7}; // J
         9'h01A: m = '{1'b1, 3'd3, 3'd0}; // Z
         9'h022: m = '{1'b1, 3'd3, 3'd1}; // X
         9'h021: m = '{1'b1, 3'd3, 3'd2}; // C
         9'h02A: m = '{1'b1, 3'd3, 3'd3}; // V
         9'h032: m = '{1'b1, 3'd3, 3'd4}; // B
         9'h031: m = '{1'b1, 3'd3, 3'd5}; // N
         9'h03A: m = '{1'b1, 3'd3, 3'd6}; // M
         9'h041: m = '{1'b1, 3'd3, 3'd7}; // ,
         9'h03E: m = '{1'b1, 3'd4, 3'd0}; // 8
         9'h046: m = '{1'b1, 3'd4, 3'd1}; // 9
         9'h045: m = '{1'b1, 3'd4, 3'd2}; // 0
         9'h043: m = '{1'b1, 3'd4, 3'd3}; // I
         9'h029: m = '{1'b1, 3'd4, 3'd4}; // Space
         9'h044: m = '{1'b1, 3'd4, 3'd5}; // O
         9'h04D: m = '{1'b1, 3'd4, 3'd6}; // P
         9'h042: m = '{1'b1, 3'd4, 3'd7}; // K
         9'h04B: m = '{1'b1, 3'd5, 3'd0}; // L
         9'h04C: m = '{1'b1, 3'd5, 3'd1}; // ;
         9'h049: m = '{1'b1, 3'd5, 3'd2}; // .
         9'h04A: m = '{1'b1, 3'd5, 3'd3}; // /
         9'h066: m = '{1'b1, 3'd5, 3'd4}; // Backspace
         9'h076: m = '{1'b1, 3'd5, 3'd5}; // Esc
         9'h00D: m = '{1'b1, 3'd5, 3'd6}; // Tab
         9'h058: m = '{1'b1, 3'd5, 3'd7}; // Caps Lock
         9'h005: m = '{1'b1, 3'd6, 3'd0}; // F1
         9'h006: m = '{1'b1, 3'd6, 3'd1}; // F2
         9'h004: m = '{1'b1, 3'd6, 3'd2}; // F3
         9'h00C: m = '{1'b1, 3'd6, 3'd3}; // F4
         9'h03C: m = '{1'b1, 3'd6, 3'd4}; // U
         9'h054: m = '{1'b1, 3'd6, 3'd5}; // [
         9'h05B: m = '{1'b1, 3'd6, 3'd6}; // ]
         9'h055: m = '{1'b1, 3'd6, 3'd7}; // =
         9'h16B: m = '{1'b1, 3'd7, 3'd0}; // E0 Left
         9'h174: m = '{1'b1, 3'd7, 3'd1}; // E0 Right
         9'h172: m = '{1'b1, 3'd7, 3'd2}; // E0 Down
         9'h175: m = '{1'b1, 3'd7, 3'd3}; // E0 Up
         9'h171: m = '{1'b1, 3'd7, 3'd4}; // E0 Delete
         9'h16C: m = '{1'b1, 3'd7, 3'd5}; // E0 Home
         9'h111: m = '{1'b1, 3'd7, 3'd6}; // E0 RAlt
         9'h114: m = '{1'b1, 3'd7, 3'd7}; // E0 RCtrl
         default: m = '{hit: 1'b0, row: 3'd0, col: 3'd0};
      endcase
      return m;
   endfunction

   // ---------------- synchroniser and clock filter ----------------
   logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
   logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
   logic          clk_filt_q, clk_filt_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic          ps2_fall;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      clk_s1_d   = bus.ps2_clk;
      clk_s2_d   = clk_s1_q;
      dat_s1_d   = bus.ps2_data;
      dat_s2_d   = dat_s1_q;
      clk_filt_d = clk_filt_q;
      filt_cnt_d = '0;
      ps2_fall   = 1'b0;
      // Count consecutive samples that disagree with the filtered level;
      // any agreeing sample restarts the count.
      if (clk_s2_q != clk_filt_q) begin
         if (filt_cnt_q == FW'(PS2_FILTER - 1)) begin
            clk_filt_d = clk_s2_q;
            ps2_fall   = clk_filt_q;
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clock or negedge RESET_n) begin
      if (!RESET_n) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
         clk_filt_q <= 1'b1;
         filt_cnt_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
         clk_s1_q   <= clk_s1_d;
         clk_s2_q   <= clk_s2_d;
         dat_s1_q   <= dat_s1_d;
         dat_s2_q   <= dat_s2_d;
         clk_filt_q <= clk_filt_d;
         filt_cnt_q <= filt_cnt_d;
      end
   end

   // ---------------- frame FSM ----------------
   frame_state_e  state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [7:0]    rx_byte_q, rx_byte_d;
   logic          byte_rdy_q, byte_rdy_d;
   logic          frame_err_q, frame_err_d;
   logic          tmo_hit;
   logic          parity_bad;

`ifdef PS2_PARITY_CHECK_EN
   // Odd parity: the eight data bits plus the parity bit hold an odd number of ones.
   assign parity_bad = ~(^{shift_q, par_q});
`else
   logic par_unused;
   assign par_unused = par_q;
   assign parity_bad = 1'b0;
`endif

   // A falling edge in the same cycle wins over an expiring timeout.
   assign tmo_hit = (state_q != ST_IDLE) && !ps2_fall &&
                    (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge sys_clock or negedge RESET_n) begin
      if (!RESET_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (tmo_hit) begin
         state_d = ST_IDLE;
      end else if (ps2_fall) begin
         case (state_q)
            ST_IDLE:   if (!dat_s2_q) state_d = ST_DATA;
            ST_DATA:   if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
            ST_PARITY: state_d = ST_STOP;
            ST_STOP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      par_d       = par_q;
      rx_byte_d   = rx_byte_q;
      byte_rdy_d  = 1'b0;
      frame_err_d = 1'b0;
      tmo_cnt_d   = (state_q == ST_IDLE || ps2_fall) ? '0 : tmo_cnt_q + 1'b1;
      if (tmo_hit) begin
         frame_err_d = 1'b1;
      end else if (ps2_fall) begin
         case (state_q)
            ST_IDLE:   bit_cnt_d = '0;
            ST_DATA: begin
               shift_d   = {dat_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
            ST_PARITY: par_d = dat_s2_q;
            ST_STOP: begin
               if (!dat_s2_q || parity_bad) begin
                  frame_err_d = 1'b1;
               end else begin
                  byte_rdy_d = 1'b1;
                  rx_byte_d  = shift_q;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge sys_clock or negedge RESET_n) begin
      if (!RESET_n) begin
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         tmo_cnt_q   <= '0;
         rx_byte_q   <= '0;
         byte_rdy_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         tmo_cnt_q   <= tmo_cnt_d;
         rx_byte_q   <= rx_byte_d;
         byte_rdy_q  <= byte_rdy_d;
         frame_err_q <= frame_err_d;
      end
   end

   // ---------------- decoder ----------------
   logic [7:0][7:0] km_q, km_d;
   logic [7:0]      scancode_q, scancode_d;
   logic            key_valid_q, key_valid_d;
   logic            ext_q, ext_d, brk_q, brk_d;
   logic [2:0]      skip_q, skip_d;
   key_map_t        hit_map;

   assign hit_map = lookup({ext_q, rx_byte_q});

   always_comb begin
      km_d        = km_q;
      scancode_d  = scancode_q;
      key_valid_d = 1'b0;
      ext_d       = ext_q;
      brk_d       = brk_q;
      skip_d      = skip_q;
      if (byte_rdy_q) begin
         scancode_d = rx_byte_q;
         if (skip_q != 3'd0) begin
            skip_d = skip_q - 1'b1;
         end else begin
            case (rx_byte_q)
               8'hE1: skip_d = 3'd7;   // drop the rest of the Pause sequence
               8'hE0: ext_d  = 1'b1;
               8'hF0: brk_d  = 1'b1;
               8'hAA, 8'hFA, 8'hEE, 8'hFE: begin
                  ext_d = 1'b0;
                  brk_d = 1'b0;
               end
               default: begin
                  if (hit_map.hit) begin
                     km_d[hit_map.row][hit_map.col] = brk_q;
                     key_valid_d = 1'b1;
                  end
                  ext_d = 1'b0;
                  brk_d = 1'b0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge sys_clock or negedge RESET_n) begin
      if (!RESET_n) begin
         // NOTE: the matrix is a flop array, not RAM, so reset can release every key at once.
         km_q        <= '1;
         scancode_q  <= '0;
         key_valid_q <= 1'b0;
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         skip_q      <= '0;
      end else begin
         km_q        <= km_d;
         scancode_q  <= scancode_d;
         key_valid_q <= key_valid_d;
         ext_q       <= ext_d;
         brk_q       <= brk_d;
         skip_q      <= skip_d;
      end
   end

   assign bus.KM        = km_q;
   assign bus.scancode  = scancode_q;
   assign bus.key_valid = key_valid_q;
   assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_lm80c_ps2_matrix.sv
// -----------------------------------------------------------------------------
// tb_lm80c_ps2_matrix
// Directed bench: sends PS/2 frames, checks the key matrix, scancode and the
// key_valid / frame_err pulse counts against hand-computed values.
// -----------------------------------------------------------------------------
module tb_lm80c_ps2_matrix;
   localparam int HALF = 20;     // sys_clock cycles per PS/2 clock half-period
   localparam int TMO  = 2000;

   logic sys_clock;
   logic RESET_n;
   lm80c_ps2_matrix_if bus();

   lm80c_ps2_matrix #(.PS2_FILTER(8), .TIMEOUT_CYC(TMO)) dut (
      .sys_clock (sys_clock),
      .RESET_n   (RESET_n),
      .bus       (bus)
   );

   initial sys_clock = 1'b0;
   always #5 sys_clock = ~sys_clock;

   int kv_cnt = 0;
   int fe_cnt = 0;
   always @(negedge sys_clock) begin
      if (bus.key_valid === 1'b1) kv_cnt++;
      if (bus.frame_err === 1'b1) fe_cnt++;
   end

   int n_pass  = 0;
   int n_total = 0;

   logic [7:0][7:0] km_exp;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge sys_clock);
   endtask

   // Sends nbits of {stop, parity, data, start}, LSB first. par_flip inverts
   // the correct odd parity bit.
   task automatic send_frame(input logic [7:0] b, input logic par_flip,
                             input logic stop, input int nbits);
      logic [10:0] f;
      f = {stop, ~(^b) ^ par_flip, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         bus.ps2_data = f[i];
         wait_cyc(HALF);
         bus.ps2_clk = 1'b0;
         wait_cyc(HALF);
         bus.ps2_clk = 1'b1;
      end
      wait_cyc(HALF);
      bus.ps2_data = 1'b1;
      wait_cyc(2 * HALF);
      @(negedge sys_clock);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b1, 11);
   endtask

   initial begin
      #(10 * 90000);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int k0, f0, waited;
   logic [7:0] pause_seq [8];

   initial begin
      pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      km_exp       = '1;
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      RESET_n      = 1'b0;
      wait_cyc(5);
      RESET_n = 1'b1;
      wait_cyc(5);
      @(negedge sys_clock);

      // Reset state
      check("reset_km", bus.KM, km_exp);
      check("reset_scancode", bus.scancode, 64'h00);
      check("reset_key_valid", bus.key_valid, 64'h0);
      check("reset_frame_err", bus.frame_err, 64'h0);

      // 1: make A
      k0 = kv_cnt;
      send_byte(8'h1C);
      km_exp[2] = 8'hFD;
      check("t1_km2", bus.KM[2], 64'hFD);
      check("t1_km", bus.KM, km_exp);
      check("t1_kv_pulses", kv_cnt - k0, 64'd1);
      check("t1_scancode", bus.scancode, 64'h1C);

      // 2: break A
      k0 = kv_cnt;
      send_byte(8'hF0);
      send_byte(8'h1C);
      km_exp[2] = 8'hFF;
      check("t2_km2", bus.KM[2], 64'hFF);
      check("t2_scancode", bus.scancode, 64'h1C);
      check("t2_kv_pulses", kv_cnt - k0, 64'd1);

      // 3: extended Up, then plain 75 (miss)
      send_byte(8'hE0);
      send_byte(8'h75);
      km_exp[7] = 8'hF7;
      check("t3_km7", bus.KM[7], 64'hF7);
      k0 = kv_cnt;
      send_byte(8'h75);
      check("t3_miss_km", bus.KM, km_exp);
      check("t3_miss_kv", kv_cnt - k0, 64'd0);
      check("t3_miss_scancode", bus.scancode, 64'h75);

      // 4: bad stop bit, then timeout, then a good frame
      f0 = fe_cnt;
      k0 = kv_cnt;
      send_frame(8'h1C, 1'b0, 1'b0, 11);
      check("t4_stop_err", fe_cnt - f0, 64'd1);
      check("t4_stop_km", bus.KM, km_exp);
      check("t4_stop_kv", kv_cnt - k0, 64'd0);

      f0 = fe_cnt;
      send_frame(8'h1C, 1'b0, 1'b1, 4);
      waited = 0;
      while (fe_cnt == f0 && waited < TMO + 500) begin
         @(negedge sys_clock);
         waited++;
      end
      check("t4_timeout_err", fe_cnt - f0, 64'd1);
      // Last fall was ~3*HALF+10 cycles before the wait began.
      check("t4_timeout_window", (waited > TMO - 300 && waited < TMO), 64'd1);
      send_byte(8'h1C);
      km_exp[2] = 8'hFD;
      check("t4_recover_km", bus.KM, km_exp);

      // 5: Enter with wrong parity
      f0 = fe_cnt;
      send_frame(8'h5A, 1'b1, 1'b1, 11);
`ifdef PS2_PARITY_CHECK_EN
      check("t5_parity_err", fe_cnt - f0, 64'd1);
      check("t5_km1", bus.KM[1], 64'hFF);
`else
      km_exp[1] = 8'hBF;
      check("t5_parity_err", fe_cnt - f0, 64'd0);
      check("t5_km1", bus.KM[1], 64'hBF);
`endif

      // 6: Pause sequence ignored, then Space
      k0 = kv_cnt;
      for (int i = 0; i < 8; i++) send_byte(pause_seq[i]);
      check("t6_pause_km", bus.KM, km_exp);
      check("t6_pause_kv", kv_cnt - k0, 64'd0);
      check("t6_pause_scancode", bus.scancode, 64'h77);
      send_byte(8'h29);
      km_exp[4] = 8'hEF;
      check("t6_space_km4", bus.KM[4], 64'hEF);
      check("t6_space_km", bus.KM, km_exp);
      check("t6_space_kv", kv_cnt - k0, 64'd1);

      // Reset mid-frame releases all keys
      send_frame(8'h29, 1'b0, 1'b1, 5);
      RESET_n = 1'b0;
      wait_cyc(3);
      @(negedge sys_clock);
      km_exp = '1;
      check("rst_mid_km", bus.KM, km_exp);
      check("rst_mid_scancode", bus.scancode, 64'h00);
      RESET_n = 1'b1;
      wait_cyc(5);
      send_byte(8'h1C);
      km_exp[2] = 8'hFD;
      check("rst_after_km", bus.KM, km_exp);
      check("rst_after_scancode", bus.scancode, 64'h1C);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
